bsg_tag_master_sender_arb: RTL and testbench

BSG_TAG_MASTER_SENDER_ARB -- requirements
Module: bsg_tag_master_sender_arb

---
 rtl/bsg_tag_master_sender_arb_pkg.sv | 34 +++
 rtl/bsg_tag_master_sender_arb_rr.sv | 59 +++++
 rtl/bsg_tag_master_sender_arb.sv | 205 ++++++++++++++++++++
 tb/tb_bsg_tag_master_sender_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_tag_master_sender_arb_pkg.sv
// Shared definitions for the tag master sender/arbiter.
// Holds the sender state encoding, the header field widths, the maximum
// payload width and a helper that lays out one packet for LSB-first shifting.
package bsg_tag_master_sender_arb_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_HDR     = 3'd3,
        ST_PAYLOAD = 3'd4
    } state_e;

    localparam int LEN_W         = 4;
    localparam int ID_W          = 4;
    localparam int MAX_PAYLOAD_W = 15;
    // Header is len, then data_not_reset, then id.
    localparam int HDR_BITS      = LEN_W + 1 + ID_W;
    // Start bit + header + payload.
    localparam int PKT_W         = 1 + HDR_BITS + MAX_PAYLOAD_W;
    localparam int CNT_W         = 5;

    // Bit 0 is the start bit; each later field follows LSB first so the
    // serializer only ever looks at the bottom of a right-shifting register.
    function automatic logic [PKT_W-1:0] pack_packet(
        input logic [ID_W-1:0]          id,
        input logic                     dnr,
        input logic [LEN_W-1:0]         len,
        input logic [MAX_PAYLOAD_W-1:0] data
    );
        return {data, id, dnr, len, 1'b1};
    endfunction

endpackage

// File: rtl/bsg_tag_master_sender_arb_rr.sv
// Round-robin one-hot arbiter.
// Ports:
//   clk_i     - clock
//   reset_n_i - synchronous active-low reset (requester 0 gets priority)
//   req_i     - request vector
//   yumi_i    - advance strobe: the current grant was taken this cycle
//   grant_o   - one-hot grant among asserted requests (combinational)
module bsg_round_robin_arb_onehot
#(
    parameter int width_p = 2
)
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] req_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] grant_o
);

    localparam int PTR_W = (width_p > 1) ? $clog2(width_p) : 1;

    logic [PTR_W-1:0]   last_r;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   idx_s;
    logic [width_p-1:0] grant_s;
    logic               found_s;

    // Scan requesters starting just after the last one served.
    always_comb begin
        grant_s = '0;
        win_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int off = 1; off <= width_p; off++) begin
            idx_s = PTR_W'((int'(last_r) + off) % width_p);
            if (!found_s && req_i[idx_s]) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                win_s          = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant_o = grant_s;

    // Remember the served requester; reset value makes requester 0 first.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            last_r <= PTR_W'(width_p - 1);
        end else if (yumi_i && found_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/bsg_tag_master_sender_arb.sv
// Arbitrated serial sender for a bsg_tag master.
// Picks one requester round-robin, then serializes a start bit, a 9-bit
// header (len[0..3], data_not_reset, id[0..3]) and len payload bits LSB first
// onto a single registered line. A master-reset request runs a long zero
// sequence between packets; hard reset runs the same sequence immediately.
// Ports:
//   clk_i           - clock
//   reset_n_i       - synchronous active-low reset
//   req_v_i         - per-requester valid
//   req_id_i        - per-requester client id, 4 bits each
//   req_dnr_i       - per-requester data_not_reset bit
//   req_len_i       - per-requester payload length, 4 bits each
//   req_data_i      - per-requester payload, 15 bits each
//   req_ready_o     - one-hot accept
//   reset_clients_i - request a master-reset zero sequence
//   tag_data_o      - serial line to the tag master
//   busy_o          - high whenever the sender is not idle
module bsg_tag_master_sender_arb
    import bsg_tag_master_sender_arb_pkg::*;
#(
    parameter int num_req_p    = 2,
    parameter int els_p        = 9,
    parameter int lg_width_p   = 4,
    parameter int init_zeros_p = 40
)
(
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*ID_W-1:0]          req_id_i,
    input  logic [num_req_p-1:0]               req_dnr_i,
    input  logic [num_req_p*LEN_W-1:0]         req_len_i,
    input  logic [num_req_p*MAX_PAYLOAD_W-1:0] req_data_i,
    output logic [num_req_p-1:0]               req_ready_o,
    input  logic                               reset_clients_i,
    output logic                               tag_data_o,
    output logic                               busy_o
);

    localparam int INIT_W = $clog2(init_zeros_p + 1);

    // Parameter sanity: these configurations cannot be represented on the wire.
    if (num_req_p < 1 || num_req_p > 8) begin : g_bad_num_req
        $error("num_req_p out of range");
    end
    if (els_p < 1 || els_p > (1 << ID_W)) begin : g_bad_els
        $error("els_p not addressable by the id field");
    end
    if (lg_width_p != LEN_W) begin : g_bad_lg_width
        $error("lg_width_p must match the length field width");
    end
    if (init_zeros_p < 33) begin : g_bad_init_zeros
        $error("init_zeros_p too short to reset the master");
    end

    state_e                  state_r, state_s;
    logic [INIT_W-1:0]       init_cnt_r, init_cnt_s;
    logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_s;
    logic [PKT_W-1:0]        shift_r, shift_s;
    logic [lg_width_p-1:0]   len_r, len_s;
    logic                    pending_r, pending_s;
    logic                    tag_r, tag_s;
    logic                    busy_r;

    logic [num_req_p-1:0]     grant_s;
    logic                     open_s;
    logic                     accept_s;
    logic [ID_W-1:0]          sel_id_s;
    logic                     sel_dnr_s;
    logic [LEN_W-1:0]         sel_len_s;
    logic [MAX_PAYLOAD_W-1:0] sel_data_s;

    bsg_round_robin_arb_onehot #(
        .width_p (num_req_p)
    ) u_rr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req_i     (req_v_i),
        .yumi_i    (accept_s),
        .grant_o   (grant_s)
    );

    // Grants are only offered when idle and no client reset is waiting.
    assign open_s      = (state_r == ST_IDLE) && !pending_r;
    assign req_ready_o = grant_s & {num_req_p{open_s}};
    assign accept_s    = |(req_v_i & req_ready_o);

    // One-hot mux of the winning requester's fields.
    always_comb begin
        sel_id_s   = '0;
        sel_dnr_s  = 1'b0;
        sel_len_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < num_req_p; i++) begin
            sel_id_s   = sel_id_s   | (req_id_i[i*ID_W +: ID_W] & {ID_W{grant_s[i]}});
            sel_dnr_s  = sel_dnr_s  | (req_dnr_i[i] & grant_s[i]);
            sel_len_s  = sel_len_s  | (req_len_i[i*LEN_W +: LEN_W] & {LEN_W{grant_s[i]}});
            sel_data_s = sel_data_s | (req_data_i[i*MAX_PAYLOAD_W +: MAX_PAYLOAD_W]
                                       & {MAX_PAYLOAD_W{grant_s[i]}});
        end
    end

    // Next state, counters, shift register and the next line bit.
    // shift_r[0] always holds the bit currently on the line, so the next bit
    // to present is shift_r[1].
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        len_s      = len_r;
        pending_s  = pending_r | reset_clients_i;
        tag_s      = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r != INIT_W'(init_zeros_p)) begin
                    init_cnt_s = init_cnt_r + INIT_W'(1);
                end else begin
                    init_cnt_s = init_cnt_r;
                end
                if (init_cnt_r >= INIT_W'(init_zeros_p - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (pending_r) begin
                    state_s    = ST_INIT;
                    init_cnt_s = '0;
                    pending_s  = 1'b0;
                end else if (accept_s) begin
                    state_s = ST_START;
                    shift_s = pack_packet(sel_id_s, sel_dnr_s, sel_len_s, sel_data_s);
                    len_s   = lg_width_p'(sel_len_s);
                    tag_s   = shift_s[0];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_s   = ST_HDR;
                bit_cnt_s = '0;
                shift_s   = {1'b0, shift_r[PKT_W-1:1]};
                tag_s     = shift_r[1];
            end
            ST_HDR: begin
                if (bit_cnt_r == CNT_W'(HDR_BITS - 1)) begin
                    if (len_r == '0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_PAYLOAD;
                        bit_cnt_s = '0;
                        shift_s   = {1'b0, shift_r[PKT_W-1:1]};
                        tag_s     = shift_r[1];
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    shift_s   = {1'b0, shift_r[PKT_W-1:1]};
                    tag_s     = shift_r[1];
                end
            end
            ST_PAYLOAD: begin
                if ((bit_cnt_r + CNT_W'(1)) == CNT_W'(len_r)) begin
                    state_s = ST_IDLE;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    shift_s   = {1'b0, shift_r[PKT_W-1:1]};
                    tag_s     = shift_r[1];
                end
            end
            default: begin
                state_s    = ST_INIT;
                init_cnt_s = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any packet and restarts INIT.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            len_r      <= '0;
            pending_r  <= 1'b0;
            tag_r      <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            len_r      <= len_s;
            pending_r  <= pending_s;
            tag_r      <= tag_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign tag_data_o = tag_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_bsg_tag_master_sender_arb.sv
module tb_bsg_tag_master_sender_arb;

    localparam int N  = 2;
    localparam int NZ = 40;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_v;
    logic [N*4-1:0]  req_id;
    logic [N-1:0]    req_dnr;
    logic [N*4-1:0]  req_len;
    logic [N*15-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            reset_clients;
    logic            tag_data;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: queue of line bits still owed, rr pointer, pending flag
    bit m_q[$];
    int m_last;
    bit m_pending;

    bsg_tag_master_sender_arb #(
        .num_req_p    (N),
        .els_p        (9),
        .lg_width_p   (4),
        .init_zeros_p (NZ)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (req_v),
        .req_id_i        (req_id),
        .req_dnr_i       (req_dnr),
        .req_len_i       (req_len),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .reset_clients_i (reset_clients),
        .tag_data_o      (tag_data),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < NZ; k++) m_q.push_back(1'b0);
        m_last    = N - 1;
        m_pending = 1'b0;
    endtask

    task automatic push_packet(input int c);
        logic [3:0]  l;
        logic [3:0]  id;
        logic [14:0] d;
        l  = req_len[c*4 +: 4];
        id = req_id[c*4 +: 4];
        d  = req_data[c*15 +: 15];
        m_q.push_back(1'b1);
        for (int b = 0; b < 4; b++) m_q.push_back(l[b]);
        m_q.push_back(req_dnr[c]);
        for (int b = 0; b < 4; b++) m_q.push_back(id[b]);
        for (int b = 0; b < int'(l); b++) m_q.push_back(d[b]);
    endtask

    // compare current-cycle outputs with the model
    task automatic check_outputs();
        logic [N-1:0] er;
        int w;
        er = '0;
        if (m_q.size() > 0) begin
            check_eq("tag", {31'b0, tag_data}, {31'b0, m_q[0]});
            check_eq("busy", {31'b0, busy}, 32'd1);
        end else begin
            check_eq("tag", {31'b0, tag_data}, 32'd0);
            check_eq("busy", {31'b0, busy}, 32'd0);
            w = rr_pick(req_v);
            if (!m_pending && w >= 0) er[w] = 1'b1;
        end
        check_eq("ready", 32'(req_ready), 32'(er));
    endtask

    // advance the model across the coming clock edge
    task automatic model_edge();
        int w;
        if (!reset_n) begin
            model_reset();
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_pending = m_pending | reset_clients;
        end else if (m_pending) begin
            for (int k = 0; k < NZ; k++) m_q.push_back(1'b0);
            m_pending = 1'b0;
        end else begin
            w = rr_pick(req_v);
            if (w >= 0) begin
                push_packet(w);
                m_last = w;
            end
            m_pending = m_pending | reset_clients;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [3:0] id, input logic dnr,
                           input logic [3:0] len, input logic [14:0] data);
        req_id[c*4 +: 4]    = id;
        req_dnr[c]          = dnr;
        req_len[c*4 +: 4]   = len;
        req_data[c*15 +: 15] = data;
    endtask

    initial begin
        int n;
        int prev;
        int grants;
        bit alt_ok;
        logic [13:0] obs;

        reset_n = 1'b0; req_v = '0; req_id = '0; req_dnr = '0;
        req_len = '0; req_data = '0; reset_clients = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step();
        step();
        check_eq("rst_tag", {31'b0, tag_data}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd1);
        check_eq("rst_ready", 32'(req_ready), 32'd0);

        // init run then idle
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        check_eq("init_len", n, NZ);
        step(); step();

        // single packet id=3 dnr=1 len=4 data=1011
        set_req(0, 4'd3, 1'b1, 4'd4, 15'b000_0000_0000_1011);
        req_v = 2'b01;
        step();
        req_v = '0;
        obs = '0;
        for (int k = 0; k < 14; k++) begin
            obs = {obs[12:0], tag_data};
            step();
        end
        check_eq("pkt_bits", 32'(obs), 32'(14'b1_0010_1_1100_1101));
        check_eq("pkt_end_busy", {31'b0, busy}, 32'd0);

        // both requesters valid continuously: grants alternate
        set_req(0, 4'd1, 1'b1, 4'd2, 15'h0003);
        set_req(1, 4'd2, 1'b0, 4'd3, 15'h0005);
        req_v = 2'b11;
        prev = -1; grants = 0; alt_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < N; c++) begin
                if (req_ready[c]) begin
                    if (c == prev) alt_ok = 1'b0;
                    prev = c;
                    grants++;
                end
            end
            step();
        end
        req_v = '0;
        check_eq("rr_alternate", {31'b0, alt_ok}, 32'd1);
        check_eq("rr_enough", {31'b0, grants >= 4}, 32'd1);
        for (int k = 0; k < 15; k++) step();

        // len=0, id=8: 10-cycle packet
        set_req(0, 4'd8, 1'b1, 4'd0, 15'h7fff);
        req_v = 2'b01;
        step();
        req_v = '0;
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        check_eq("len0_cycles", n, 10);
        step();

        // reset_clients pulsed at header bit 2, next request waiting
        set_req(0, 4'd5, 1'b1, 4'd6, 15'h002a);
        set_req(1, 4'd6, 1'b1, 4'd1, 15'h0001);
        req_v = 2'b01;
        step();
        req_v = 2'b10;
        step(); step(); step();
        reset_clients = 1'b1;
        step();
        reset_clients = 1'b0;
        for (int k = 0; k < 80; k++) step();
        req_v = '0;
        for (int k = 0; k < 15; k++) step();

        // hard reset mid-payload
        set_req(0, 4'd2, 1'b0, 4'd8, 15'h00ff);
        req_v = 2'b01;
        step();
        req_v = '0;
        for (int k = 0; k < 12; k++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("abort_tag", {31'b0, tag_data}, 32'd0);
        for (int k = 0; k < 50; k++) step();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            req_v = N'($urandom_range(0, (1 << N) - 1));
            for (int c = 0; c < N; c++) begin
                set_req(c, 4'($urandom), 1'($urandom), 4'($urandom), 15'($urandom));
            end
            reset_clients = ($urandom_range(0, 63) == 0);
            reset_n = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1; reset_clients = 1'b0; req_v = '0;
        for (int k = 0; k < 60; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
